axi4_lite_read_arbiter: RTL and testbench

- Shares one AXI4-Lite read slave port among NO_OF_MASTERS AXI4-Lite read masters.
- Uses round-robin arbitration with one transaction outstanding at a time.
- Requests whose address falls outside the slave window [MIN_ADDRESS, MAX_ADDRESS] get a local DECERR response and are never forwarded.
- Sits between the master-side read VIP/RTL requesters and the read slave, inside the axi4Lite read-slave environment.

---
 rtl/axi4_lite_read_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read slave among several read masters.
// One transaction in flight; reads outside [MIN_ADDRESS, MAX_ADDRESS] are answered locally with DECERR.
module axi4_lite_read_arbiter #(
  parameter int                       NO_OF_MASTERS = 2,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = '0,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = '1,
  parameter int                       GW            = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0] m_araddr,
  input  logic [NO_OF_MASTERS*3-1:0]             m_arprot,
  input  logic [NO_OF_MASTERS-1:0]               m_arvalid,
  output logic [NO_OF_MASTERS-1:0]               m_arready,
  output logic [DATA_WIDTH-1:0]                  m_rdata,
  output logic [1:0]                             m_rresp,
  output logic [NO_OF_MASTERS-1:0]               m_rvalid,
  input  logic [NO_OF_MASTERS-1:0]               m_rready,
  output logic [ADDRESS_WIDTH-1:0]               s_araddr,
  output logic [2:0]                             s_arprot,
  output logic                                   s_arvalid,
  input  logic                                   s_arready,
  input  logic [DATA_WIDTH-1:0]                  s_rdata,
  input  logic [1:0]                             s_rresp,
  input  logic                                   s_rvalid,
  output logic                                   s_rready,
  output logic [GW-1:0]                          grant_id,
  output logic                                   busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DERR = 2'd3;
  localparam int         RW      = $clog2(2 * NO_OF_MASTERS);

  logic [1:0]                 r_state;
  logic [GW-1:0]              r_grant_id;
  logic [GW-1:0]              r_last_grant;
  logic [ADDRESS_WIDTH-1:0]   r_addr_q;
  logic [2:0]                 r_prot_q;

  logic [2*NO_OF_MASTERS-1:0] w_req2;
  logic [RW-1:0]              w_idx;
  logic                       w_found;
  logic [GW-1:0]              w_winner;
  logic [NO_OF_MASTERS-1:0]   w_win_oh;
  logic [NO_OF_MASTERS-1:0]   w_gnt_oh;
  logic                       w_rready_g;
  logic [ADDRESS_WIDTH-1:0]   w_sel_addr;
  logic [2:0]                 w_sel_prot;
  logic                       w_ge_min;
  logic                       w_le_max;
  logic                       w_in_range;

  // Doubled request vector lets the scan start at last_grant+1 without a modulo on the bit index.
  assign w_req2 = {m_arvalid, m_arvalid};

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NO_OF_MASTERS; k >= 1; k--) begin
      w_idx = RW'(int'(r_last_grant) + k);
      if (w_req2[w_idx]) begin
        w_found  = 1'b1;
        w_winner = GW'((int'(r_last_grant) + k) % NO_OF_MASTERS);
      end
    end
  end

  assign w_win_oh   = w_found ? (NO_OF_MASTERS'(1) << w_winner) : '0;
  assign w_gnt_oh   = NO_OF_MASTERS'(1) << r_grant_id;
  assign w_rready_g = |(m_rready & w_gnt_oh);
  assign w_sel_addr = ADDRESS_WIDTH'(m_araddr >> (int'(w_winner) * ADDRESS_WIDTH));
  assign w_sel_prot = 3'(m_arprot >> (int'(w_winner) * 3));

  // Bounds that cover the whole address space need no comparator.
  if (MIN_ADDRESS == '0) begin : g_no_min
    assign w_ge_min = 1'b1;
  end else begin : g_min
    assign w_ge_min = (w_sel_addr >= MIN_ADDRESS);
  end

  if (MAX_ADDRESS == '1) begin : g_no_max
    assign w_le_max = 1'b1;
  end else begin : g_max
    assign w_le_max = (w_sel_addr <= MAX_ADDRESS);
  end

  assign w_in_range = w_ge_min & w_le_max;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NO_OF_MASTERS - 1);
      r_addr_q     <= '0;
      r_prot_q     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_addr_q     <= w_sel_addr;
            r_prot_q     <= w_sel_prot;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= w_in_range ? ST_ADDR : ST_DERR;
          end
        end
        ST_ADDR: if (s_arready) r_state <= ST_DATA;
        ST_DATA: if (s_rvalid && w_rready_g) r_state <= ST_IDLE;
        ST_DERR: if (w_rready_g) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The AR handshake completes in the arbitration cycle itself, so arready is combinational.
  assign m_arready = ((r_state == ST_IDLE) && !areset) ? w_win_oh : '0;
  assign s_arvalid = (r_state == ST_ADDR);
  assign s_araddr  = r_addr_q;
  assign s_arprot  = r_prot_q;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    m_rresp  = 2'b00;
    s_rready = 1'b0;
    case (r_state)
      ST_DATA: begin
        m_rvalid = s_rvalid ? w_gnt_oh : '0;
        m_rdata  = s_rdata;
        m_rresp  = s_rresp;
        s_rready = w_rready_g;
      end
      ST_DERR: begin
        m_rvalid = w_gnt_oh;
        m_rresp  = 2'b11;
      end
      default: begin
        m_rvalid = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Bench for axi4_lite_read_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_axi4_lite_read_arbiter;

  localparam int          N    = 3;
  localparam logic [31:0] MINA = 32'h0000_0010;
  localparam logic [31:0] MAXA = 32'h0000_1FFF;

  logic          aclk = 1'b0;
  logic          areset;
  logic [95:0]   m_araddr;
  logic [8:0]    m_arprot;
  logic [2:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic [31:0]   s_araddr;
  logic [2:0]    s_arprot;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic [1:0]    grant_id;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  axi4_lite_read_arbiter #(
    .NO_OF_MASTERS(N), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .MIN_ADDRESS(MINA), .MAX_ADDRESS(MAXA)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [2:0] p);
    m_araddr = (m_araddr & ~(96'hFFFF_FFFF << (i * 32))) | (96'(a) << (i * 32));
    m_arprot = (m_arprot & ~(9'b111 << (i * 3))) | (9'(p) << (i * 3));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_000F;
      1:       return 32'h0000_0010;
      2:       return 32'h0000_1FFF;
      3:       return 32'h0000_2000;
      4:       return 32'($urandom_range(32'h10, 32'h1FFF));
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference model: at most one open transaction, described by who owns it and how far it got.
  bit          md_active, md_err, md_fwd, found;
  int          md_last = N - 1;
  int          md_gid, win, idx;
  logic [2:0]  md_oh;
  logic [31:0] md_addr;
  logic [2:0]  md_prot;
  logic [2:0]  e_arready, e_rvalid;
  logic [31:0] e_rdata;
  logic [1:0]  e_rresp;
  logic        e_sarvalid, e_srready, e_busy;

  always @(negedge aclk) begin
    e_arready = '0; e_rvalid = '0; e_rdata = '0; e_rresp = '0;
    e_sarvalid = 1'b0; e_srready = 1'b0; e_busy = 1'b0; found = 1'b0; win = 0;
    if (areset) begin
      md_active = 1'b0; md_last = N - 1; md_gid = 0;
      chk("rst_s_araddr", 64'(s_araddr), 64'(0));
      chk("rst_s_arprot", 64'(s_arprot), 64'(0));
    end else if (!md_active) begin
      for (int k = 1; k <= N; k++) begin
        idx = (md_last + k) % N;
        if (!found && ((m_arvalid >> idx) & 3'b001) != 3'b000) begin
          found = 1'b1;
          win = idx;
        end
      end
      if (found) e_arready = 3'(1 << win);
    end else begin
      e_busy = 1'b1;
      if (md_err) begin
        e_rvalid = md_oh; e_rresp = 2'b11;
      end else if (!md_fwd) begin
        e_sarvalid = 1'b1;
      end else begin
        e_rvalid  = s_rvalid ? md_oh : 3'b000;
        e_rdata   = s_rdata;
        e_rresp   = s_rresp;
        e_srready = (m_rready & md_oh) != 3'b000;
      end
    end
    chk("m_arready", 64'(m_arready), 64'(e_arready));
    chk("m_rvalid",  64'(m_rvalid),  64'(e_rvalid));
    chk("m_rdata",   64'(m_rdata),   64'(e_rdata));
    chk("m_rresp",   64'(m_rresp),   64'(e_rresp));
    chk("s_arvalid", 64'(s_arvalid), 64'(e_sarvalid));
    chk("s_rready",  64'(s_rready),  64'(e_srready));
    chk("busy",      64'(busy),      64'(e_busy));
    chk("grant_id",  64'(grant_id),  64'(md_gid));
    if (e_sarvalid) begin
      chk("s_araddr", 64'(s_araddr), 64'(md_addr));
      chk("s_arprot", 64'(s_arprot), 64'(md_prot));
    end
    if (!areset) begin
      if (!md_active) begin
        if (found) begin
          md_active = 1'b1; md_fwd = 1'b0;
          md_last = win; md_gid = win; md_oh = 3'(1 << win);
          md_addr = 32'(m_araddr >> (win * 32));
          md_prot = 3'(m_arprot >> (win * 3));
          md_err  = !(md_addr >= MINA && md_addr <= MAXA);
        end
      end else if (md_err) begin
        if ((m_rready & md_oh) != 3'b000) md_active = 1'b0;
      end else if (!md_fwd) begin
        if (s_arready) md_fwd = 1'b1;
      end else if (s_rvalid && (m_rready & md_oh) != 3'b000) begin
        md_active = 1'b0;
      end
    end
  end

  int          got [6];
  int          ng = 0;
  logic [2:0]  req, ar_hs;
  bit          s_ar_hs, s_r_hs, spend;

  initial begin
    areset = 1'b1; m_araddr = '0; m_arprot = '0; m_arvalid = 3'b111; m_rready = 3'b000;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
    set_req(0, 32'h10, 3'd0); set_req(1, 32'h20, 3'd1); set_req(2, 32'h30, 3'd2);

    repeat (3) tick();
    #2;
    chk("rst_arready", 64'(m_arready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rvalid", 64'(m_rvalid), 64'(0));

    // Round robin with all three masters requesting and a zero-wait slave.
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5555_0000; m_rready = 3'b111;
    tick();
    areset = 1'b0;
    for (int c = 0; c < 18; c++) begin
      #2;
      if (m_arready != 3'b000) begin
        chk("rr_onehot", 64'($countones(m_arready)), 64'(1));
        if (ng < 6) begin
          got[ng] = (m_arready == 3'b001) ? 0 : (m_arready == 3'b010) ? 1 : 2;
          ng++;
        end
      end
      if (c == 1) chk("rr_first_gid", 64'(grant_id), 64'(0));
      tick();
    end
    chk("rr_count", 64'(ng), 64'(6));
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(got[i]), 64'(i % 3));
    m_arvalid = 3'b000;
    for (int w = 0; w < 10 && busy; w++) tick();
    chk("idle_wait", 64'(busy), 64'(0));
    s_rvalid = 1'b0;

    // Single forwarded read from master 1 at the lower window bound.
    m_arvalid = 3'b010; set_req(1, 32'h10, 3'b101);
    #2 chk("sr_arready", 64'(m_arready), 64'(3'b010));
    tick(); m_arvalid = 3'b000;
    #2 chk("sr_s_arvalid", 64'(s_arvalid), 64'(1));
    chk("sr_s_araddr", 64'(s_araddr), 64'(32'h10));
    chk("sr_s_arprot", 64'(s_arprot), 64'(3'b101));
    tick(); s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001; s_rresp = 2'b00;
    #2 chk("sr_m_rvalid", 64'(m_rvalid), 64'(3'b010));
    chk("sr_m_rdata", 64'(m_rdata), 64'(32'hCAFE_0001));
    chk("sr_s_rready", 64'(s_rready), 64'(1));
    tick(); s_rvalid = 1'b0;
    #2 chk("sr_busy_t3", 64'(busy), 64'(0));

    // Out-of-window read answered locally.
    tick(); m_arvalid = 3'b001; set_req(0, 32'h2000, 3'd0);
    #2 chk("de_arready", 64'(m_arready), 64'(3'b001));
    tick(); m_arvalid = 3'b000;
    #2 chk("de_m_rvalid", 64'(m_rvalid), 64'(3'b001));
    chk("de_m_rresp", 64'(m_rresp), 64'(2'b11));
    chk("de_m_rdata", 64'(m_rdata), 64'(0));
    chk("de_s_arvalid", 64'(s_arvalid), 64'(0));
    tick();
    #2 chk("de_busy", 64'(busy), 64'(0));

    // Slave AR backpressure, then master R backpressure, with competing requesters.
    tick(); s_arready = 1'b0; m_arvalid = 3'b100;
    set_req(2, 32'h1FFF, 3'b010); set_req(0, 32'h20, 3'd0); set_req(1, 32'h30, 3'd1);
    #2 chk("bp_arready", 64'(m_arready), 64'(3'b100));
    tick(); m_arvalid = 3'b011;
    for (int c = 0; c < 4; c++) begin
      #2 chk("bp_s_arvalid", 64'(s_arvalid), 64'(1));
      chk("bp_s_araddr", 64'(s_araddr), 64'(32'h1FFF));
      chk("bp_no_grant", 64'(m_arready), 64'(0));
      tick();
    end
    s_arready = 1'b1;
    #2 chk("bp_s_araddr_rel", 64'(s_araddr), 64'(32'h1FFF));
    tick(); s_rvalid = 1'b1; s_rdata = 32'hBEEF_0002; m_rready = 3'b011;
    for (int c = 0; c < 3; c++) begin
      #2 chk("bp_m_rvalid", 64'(m_rvalid), 64'(3'b100));
      chk("bp_s_rready", 64'(s_rready), 64'(0));
      chk("bp_no_grant_r", 64'(m_arready), 64'(0));
      tick();
    end
    m_rready = 3'b111;
    #2 chk("bp_s_rready_rel", 64'(s_rready), 64'(1));
    tick(); s_rvalid = 1'b0;
    #2 chk("bp_next_grant", 64'(m_arready), 64'(3'b001));

    // Reset while a forwarded read sits in the data phase.
    tick(); m_arvalid = 3'b000;
    tick(); s_rvalid = 1'b1; m_rready = 3'b000;
    #1 chk("mr_pre_rvalid", 64'(m_rvalid), 64'(3'b001));
    #1 areset = 1'b1;
    #1 chk("mr_rvalid", 64'(m_rvalid), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_s_rready", 64'(s_rready), 64'(0));
    chk("mr_m_rdata", 64'(m_rdata), 64'(0));
    tick(); tick();
    areset = 1'b0; s_rvalid = 1'b0; m_rready = 3'b111; m_arvalid = 3'b111;
    #2 chk("mr_prio0", 64'(m_arready), 64'(3'b001));
    chk("mr_gid", 64'(grant_id), 64'(0));

    // Random traffic with an occasional reset.
    req = 3'b111; ar_hs = m_arready & m_arvalid; s_ar_hs = 1'b0; s_r_hs = 1'b0; spend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (s_r_hs) begin s_rvalid = 1'b0; spend = 1'b0; end
      if (s_ar_hs) spend = 1'b1;
      if (spend && !s_rvalid && $urandom_range(0, 1) == 1) begin
        s_rvalid = 1'b1; s_rdata = $urandom; s_rresp = 2'($urandom_range(0, 3));
      end
      req = req & ~ar_hs;
      for (int i = 0; i < N; i++) begin
        if (((req >> i) & 3'b001) == 3'b000 && $urandom_range(0, 2) == 0) begin
          req = req | 3'(1 << i);
          set_req(i, pick(), 3'($urandom_range(0, 7)));
        end
      end
      m_arvalid = req;
      m_rready  = 3'($urandom);
      s_arready = 1'($urandom_range(0, 1));
      areset    = ($urandom_range(0, 299) == 0);
      if (areset) begin spend = 1'b0; s_rvalid = 1'b0; end
      #2;
      ar_hs   = m_arready & m_arvalid;
      s_ar_hs = s_arvalid & s_arready;
      s_r_hs  = s_rvalid & s_rready;
    end
    tick(); areset = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
